// File: rtl/button_event_decoder.sv
// Converts a debounced button level into registered one-cycle event pulses:
// press, release, short press, long press and double click.
module button_event_decoder #(
  parameter int unsigned LONG_PRESS_LIMIT = 12_500_000,
  parameter int unsigned DOUBLE_CLICK_GAP = 5_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Debounced,
  output logic o_Pressed,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Click
);

  localparam int unsigned MAX_LIMIT =
    (LONG_PRESS_LIMIT > DOUBLE_CLICK_GAP) ? LONG_PRESS_LIMIT : DOUBLE_CLICK_GAP;
  localparam int unsigned CW = $clog2(MAX_LIMIT + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_LIMIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_CLICK_GAP - 1);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_PRESSED     = 3'd1;
  localparam logic [2:0] ST_LONG_HELD   = 3'd2;
  localparam logic [2:0] ST_WAIT_GAP    = 3'd3;
  localparam logic [2:0] ST_SECOND_HELD = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          prev_q;
  logic          press_pulse_q, release_pulse_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          dbl_q, dbl_d;
  logic          rise, fall;

  assign rise = i_Debounced & ~prev_q;
  assign fall = ~i_Debounced & prev_q;

  // The counter only advances in the two timed states; every exit clears it,
  // so each state entry starts from zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (rise) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_WAIT_GAP;
          count_d = '0;
        end else if (count_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          count_d = '0;
          long_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        count_d = '0;
        if (fall) state_d = ST_IDLE;
      end
      ST_WAIT_GAP: begin
        if (rise) begin
          state_d = ST_SECOND_HELD;
          count_d = '0;
          dbl_d   = 1'b1;
        end else if (count_q == GAP_LAST) begin
          state_d = ST_IDLE;
          count_d = '0;
          short_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_SECOND_HELD: begin
        count_d = '0;
        if (fall) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      prev_q          <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_q         <= 1'b0;
      long_q          <= 1'b0;
      dbl_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      prev_q          <= i_Debounced;
      press_pulse_q   <= rise;
      release_pulse_q <= fall;
      short_q         <= short_d;
      long_q          <= long_d;
      dbl_q           <= dbl_d;
    end
  end

  assign o_Pressed       = prev_q;
  assign o_Press_Pulse   = press_pulse_q;
  assign o_Release_Pulse = release_pulse_q;
  assign o_Short_Press   = short_q;
  assign o_Long_Press    = long_q;
  assign o_Double_Click  = dbl_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Vector-table bench for button_event_decoder with LONG_PRESS_LIMIT=8,
// DOUBLE_CLICK_GAP=4; expected outputs are queued per cycle and popped after each edge.
module tb_button_event_decoder;

  // Expected output order: {pressed, press, release, short, long, double}
  typedef struct {
    logic       rst;
    logic       din;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic o_Pressed, o_Press_Pulse, o_Release_Pulse;
  logic o_Short_Press, o_Long_Press, o_Double_Click;

  int unsigned total = 0;
  int unsigned bad   = 0;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_PRESS_LIMIT(8),
    .DOUBLE_CLICK_GAP(4)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Debounced    (din),
    .o_Pressed      (o_Pressed),
    .o_Press_Pulse  (o_Press_Pulse),
    .o_Release_Pulse(o_Release_Pulse),
    .o_Short_Press  (o_Short_Press),
    .o_Long_Press   (o_Long_Press),
    .o_Double_Click (o_Double_Click)
  );

  function automatic logic [5:0] outs();
    return {o_Pressed, o_Press_Pulse, o_Release_Pulse,
            o_Short_Press, o_Long_Press, o_Double_Click};
  endfunction

  task automatic add(input logic r, input logic d, input logic [5:0] e, input int n = 1);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b (P Pp Rp S L D) t=%0t", name, got, exp, $time);
    end
  endtask

  initial begin
    // 1: reset held with input low
    add(1, 0, 6'b000000, 20);
    add(0, 0, 6'b000000, 2);
    // 2: short press, release at N+3, short at N+7
    add(0, 1, 6'b110000);
    add(0, 1, 6'b100000, 2);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 3);
    add(0, 0, 6'b000100);
    add(0, 0, 6'b000000, 2);
    // 3: long hold of 20 cycles, long at N+8
    add(0, 1, 6'b110000);
    add(0, 1, 6'b100000, 7);
    add(0, 1, 6'b100010);
    add(0, 1, 6'b100000, 11);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 6);
    // 4: double click, second press two cycles after release
    add(0, 1, 6'b110000);
    add(0, 1, 6'b100000, 2);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000);
    add(0, 1, 6'b110001);
    add(0, 1, 6'b100000, 2);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 8);
    // 5a: release exactly at N+8 wins over long press
    add(0, 1, 6'b110000);
    add(0, 1, 6'b100000, 7);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 3);
    add(0, 0, 6'b000100);
    add(0, 0, 6'b000000, 2);
    // 5b: second press at R+4 is still a double click
    add(0, 1, 6'b110000);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 3);
    add(0, 1, 6'b110001);
    add(0, 1, 6'b100000);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 6);
    // 5c: second press at R+5 -> short at R+4, then a fresh first press
    add(0, 1, 6'b110000);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 3);
    add(0, 0, 6'b000100);
    add(0, 1, 6'b110000);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 3);
    add(0, 0, 6'b000100);
    add(0, 0, 6'b000000, 2);
    // 6: reset during the gap discards the pending short press
    add(0, 1, 6'b110000);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000);
    add(1, 0, 6'b000000, 2);
    add(0, 0, 6'b000000, 8);
    // input already high when reset releases -> normal press
    add(1, 1, 6'b000000, 2);
    add(0, 1, 6'b110000);
    add(0, 1, 6'b100000);
    add(0, 0, 6'b001000);
    add(0, 0, 6'b000000, 3);
    add(0, 0, 6'b000100);
    add(0, 0, 6'b000000, 2);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      din = vecs[i].din;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty vec=%0d got=%b exp=none", i, outs());
      end else begin
        check($sformatf("vec%0d", i), outs(), exp_q.pop_front());
      end
    end

    // Asynchronous reset mid-cycle while the button is held
    @(negedge clk);
    din = 1'b1;
    @(posedge clk);
    #1;
    check("async_pre_pressed", outs(), 6'b110000);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_mid_cycle", outs(), 6'b000000);
    @(posedge clk);
    #1;
    check("async_held", outs(), 6'b000000);
    @(negedge clk);
    din = 1'b0;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("post_async_idle", outs(), 6'b000000);
    end

    check("scoreboard_drained", 6'(exp_q.size()), 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
